// File: rtl/radiant_trig_pkg.sv
// Shared types and defaults for the RADIANT N-of-M coincidence trigger.
package radiant_trig_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HOLDOFF = 2'd1,
        ST_REARM   = 2'd2
    } trig_state_t;

    localparam int unsigned DEF_NUM_CH         = 24;
    localparam int unsigned DEF_NUM_TRIG       = 4;
    localparam int unsigned DEF_WINDOW_WIDTH   = 8;
    localparam int unsigned DEF_THRESH_WIDTH   = 5;
    localparam int unsigned DEF_HOLDOFF_WIDTH  = 16;
    localparam int unsigned DEF_PRESCALE_WIDTH = 8;
    localparam int unsigned DEF_COUNT_WIDTH    = 32;

    // Bits needed to hold a count of 0..n active channels.
    function automatic int unsigned popcnt_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/radiant_coinc_unit.sv
// One coincidence trigger: channel stretch, popcount, fire FSM, prescale,
// fired-pattern capture and saturating counters.
module radiant_coinc_unit
    import radiant_trig_pkg::*;
#(
    parameter int unsigned NUM_CH         = DEF_NUM_CH,
    parameter int unsigned WINDOW_WIDTH   = DEF_WINDOW_WIDTH,
    parameter int unsigned THRESH_WIDTH   = DEF_THRESH_WIDTH,
    parameter int unsigned HOLDOFF_WIDTH  = DEF_HOLDOFF_WIDTH,
    parameter int unsigned PRESCALE_WIDTH = DEF_PRESCALE_WIDTH,
    parameter int unsigned COUNT_WIDTH    = DEF_COUNT_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_CH-1:0]         trig,
    input  logic                      en,
    input  logic [NUM_CH-1:0]         mask,
    input  logic [WINDOW_WIDTH-1:0]   window,
    input  logic [THRESH_WIDTH-1:0]   thresh,
    input  logic [HOLDOFF_WIDTH-1:0]  holdoff,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    input  logic                      veto,
    input  logic                      count_clear,
    output logic                      pulse,
    output logic [NUM_CH-1:0]         pattern,
    output logic [COUNT_WIDTH-1:0]    raw_count,
    output logic [COUNT_WIDTH-1:0]    acc_count
);

    localparam int unsigned CNT_W = popcnt_width(NUM_CH);

    logic [NUM_CH-1:0][WINDOW_WIDTH-1:0] st;
    logic [NUM_CH-1:0]                   active;
    logic [NUM_CH-1:0]                   act_q;
    logic [CNT_W-1:0]                    sum;
    logic [CNT_W-1:0]                    cnt;
    logic                                coinc;
    logic                                fire;
    logic                                accept;
    trig_state_t                         state;
    trig_state_t                         state_nx;
    logic [HOLDOFF_WIDTH-1:0]            hcnt;
    logic [PRESCALE_WIDTH-1:0]           ph;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (!en)
                    st[i] <= '0;
                else if (trig[i] && mask[i])
                    st[i] <= window;
                else if (st[i] != '0)
                    st[i] <= st[i] - WINDOW_WIDTH'(1);
            end
        end
    end

    always_comb begin
        active = '0;
        sum    = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            active[i] = (st[i] != '0);
            sum       = sum + CNT_W'(active[i]);
        end
    end

    // The pattern reported at a fire is the set that was counted, so it is
    // registered alongside cnt rather than taken from the live stretch bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            act_q <= '0;
        end else if (!en) begin
            cnt   <= '0;
            act_q <= '0;
        end else begin
            cnt   <= sum;
            act_q <= active;
        end
    end

    assign coinc  = (thresh != '0) && (32'(cnt) >= 32'(thresh));
    assign accept = fire && (ph == prescale);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        fire     = 1'b0;
        if (!en) begin
            state_nx = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (coinc && !veto) begin
                        fire     = 1'b1;
                        state_nx = ST_HOLDOFF;
                    end
                end
                ST_HOLDOFF: begin
                    if (hcnt == '0)
                        state_nx = ST_REARM;
                end
                ST_REARM: begin
                    if (!coinc)
                        state_nx = ST_IDLE;
                end
                default: state_nx = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            hcnt <= '0;
        else if (fire)
            hcnt <= holdoff;
        else if (state == ST_HOLDOFF && hcnt != '0)
            hcnt <= hcnt - HOLDOFF_WIDTH'(1);
    end

    // A clear on a fire edge still lets the pulse out from the old phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pulse     <= 1'b0;
            pattern   <= '0;
            raw_count <= '0;
            acc_count <= '0;
            ph        <= '0;
        end else begin
            pulse <= accept;
            if (fire)
                pattern <= act_q;
            if (count_clear) begin
                raw_count <= '0;
                acc_count <= '0;
                ph        <= '0;
            end else if (fire) begin
                if (raw_count != '1)
                    raw_count <= raw_count + COUNT_WIDTH'(1);
                if (accept) begin
                    ph <= '0;
                    if (acc_count != '1)
                        acc_count <= acc_count + COUNT_WIDTH'(1);
                end else begin
                    ph <= ph + PRESCALE_WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: rtl/radiant_coinc_trig.sv
// NUM_TRIG independent N-of-M coincidence triggers over the oneshot channel
// flags; each trigger's configuration is a slice of the flat config buses.
module radiant_coinc_trig
    import radiant_trig_pkg::*;
#(
    parameter int unsigned NUM_CH         = DEF_NUM_CH,
    parameter int unsigned NUM_TRIG       = DEF_NUM_TRIG,
    parameter int unsigned WINDOW_WIDTH   = DEF_WINDOW_WIDTH,
    parameter int unsigned THRESH_WIDTH   = DEF_THRESH_WIDTH,
    parameter int unsigned HOLDOFF_WIDTH  = DEF_HOLDOFF_WIDTH,
    parameter int unsigned PRESCALE_WIDTH = DEF_PRESCALE_WIDTH,
    parameter int unsigned COUNT_WIDTH    = DEF_COUNT_WIDTH
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic [NUM_CH-1:0]                   trig_i,
    input  logic [NUM_TRIG-1:0]                 en_i,
    input  logic [NUM_TRIG*NUM_CH-1:0]          maskb_i,
    input  logic [NUM_TRIG*WINDOW_WIDTH-1:0]    window_i,
    input  logic [NUM_TRIG*THRESH_WIDTH-1:0]    thresh_i,
    input  logic [NUM_TRIG*HOLDOFF_WIDTH-1:0]   holdoff_i,
    input  logic [NUM_TRIG*PRESCALE_WIDTH-1:0]  prescale_i,
    input  logic                                veto_i,
    input  logic                                count_clear_i,
    output logic [NUM_TRIG-1:0]                 trig_o,
    output logic [NUM_TRIG*NUM_CH-1:0]          pattern_o,
    output logic [NUM_TRIG*COUNT_WIDTH-1:0]     raw_count_o,
    output logic [NUM_TRIG*COUNT_WIDTH-1:0]     acc_count_o
);

    for (genvar t = 0; t < NUM_TRIG; t++) begin : g_trig
        radiant_coinc_unit #(
            .NUM_CH        (NUM_CH),
            .WINDOW_WIDTH  (WINDOW_WIDTH),
            .THRESH_WIDTH  (THRESH_WIDTH),
            .HOLDOFF_WIDTH (HOLDOFF_WIDTH),
            .PRESCALE_WIDTH(PRESCALE_WIDTH),
            .COUNT_WIDTH   (COUNT_WIDTH)
        ) u_unit (
            .clk        (clk_i),
            .rst_n      (rst_ni),
            .trig       (trig_i),
            .en         (en_i[t]),
            .mask       (maskb_i[t*NUM_CH +: NUM_CH]),
            .window     (window_i[t*WINDOW_WIDTH +: WINDOW_WIDTH]),
            .thresh     (thresh_i[t*THRESH_WIDTH +: THRESH_WIDTH]),
            .holdoff    (holdoff_i[t*HOLDOFF_WIDTH +: HOLDOFF_WIDTH]),
            .prescale   (prescale_i[t*PRESCALE_WIDTH +: PRESCALE_WIDTH]),
            .veto       (veto_i),
            .count_clear(count_clear_i),
            .pulse      (trig_o[t]),
            .pattern    (pattern_o[t*NUM_CH +: NUM_CH]),
            .raw_count  (raw_count_o[t*COUNT_WIDTH +: COUNT_WIDTH]),
            .acc_count  (acc_count_o[t*COUNT_WIDTH +: COUNT_WIDTH])
        );
    end

endmodule

// File: doc/radiant_coinc_trig.md
Name: radiant_coinc_trig

Overview:
- Parametrised successor to the fixed 24-channel, 2-trigger combiner.
- Takes per-channel single-cycle trigger flags, already synchronised to clk_i by the per-channel oneshots. Produces NUM_TRIG independent N-of-M coincidence triggers.
- Adds behaviour the current combiner lacks: per-trigger holdoff, edge re-arm, veto, prescale, fired-channel pattern capture, saturating raw and accepted counters.
- Sits between the oneshot array and the event controller; configuration arrives as static ports from the trigger-control register space.

Parameters:
- NUM_CH, 24, number of trigger input channels
- NUM_TRIG, 4, number of independent coincidence triggers
- WINDOW_WIDTH, 8, bits of per-trigger coincidence stretch, in clk_i cycles
- THRESH_WIDTH, 5, bits of per-trigger N-of-M threshold; must satisfy 2^THRESH_WIDTH > NUM_CH
- HOLDOFF_WIDTH, 16, bits of per-trigger dead time after a fire
- PRESCALE_WIDTH, 8, bits of per-trigger prescale divisor minus one
- COUNT_WIDTH, 32, bits of each per-trigger counter

Ports:
- clk_i  in  1  single clock (trigger-logic clock)
- rst_ni  in  1  asynchronous, active-low reset
- trig_i  in  NUM_CH  single-cycle channel flags
- en_i  in  NUM_TRIG  per-trigger enable
- maskb_i  in  NUM_TRIG*NUM_CH  channel-included bits for each trigger
- window_i  in  NUM_TRIG*WINDOW_WIDTH  coincidence window per trigger
- thresh_i  in  NUM_TRIG*THRESH_WIDTH  required active-channel count per trigger
- holdoff_i  in  NUM_TRIG*HOLDOFF_WIDTH  dead cycles after each fire
- prescale_i  in  NUM_TRIG*PRESCALE_WIDTH  accept one of every (prescale+1) fires
- veto_i  in  1  global veto, level
- count_clear_i  in  1  synchronous clear of counters and prescale phase
- trig_o  out  NUM_TRIG  one-cycle accepted-trigger pulse
- pattern_o  out  NUM_TRIG*NUM_CH  active-channel pattern captured at the last fire
- raw_count_o  out  NUM_TRIG*COUNT_WIDTH  fires before prescale
- acc_count_o  out  NUM_TRIG*COUNT_WIDTH  trig_o pulses

Behaviour:
- Reset: every output and internal register is 0; all FSMs go to IDLE.
- Stretch, per trigger t and channel c:
  - Edge n samples trig_i[c]=1 with maskb_i[t][c]=1 and en_i[t]=1: st[t][c] <= window_i[t].
  - Otherwise, if st is nonzero, it decrements.
  - Channel is active while st != 0, i.e. for W cycles after the sampling edge.
  - A retrigger reloads the counter to W.
  - window_i=0 means no channel ever activates.
- Coincidence:
  - Edge n+1 registers popcount of active channels into cnt[t].
  - coinc[t] = (cnt[t] >= thresh_i[t]) && thresh_i[t] != 0; thresh=0 never fires.
- FSM per trigger, states IDLE, HOLDOFF, REARM:
  - IDLE: coinc && !veto_i → fire at edge n+2, then go to HOLDOFF with hcnt <= holdoff_i.
    - A fire does: raw_count++, latch pattern_o[t] from the active bits, apply prescale.
  - HOLDOFF: hcnt decrements; at 0 go to REARM. holdoff=0 goes to REARM on the next edge.
  - REARM: return to IDLE only on a cycle with coinc=0. The same standing coincidence never refires.
  - A coincidence during veto or HOLDOFF is dropped, not queued.
- Prescale:
  - Phase counter ph[t] counts fires.
  - When ph == prescale_i[t]: trig_o[t]=1 for one cycle, acc_count++, ph <= 0. Otherwise ph++.
  - prescale=0 accepts every fire.
- Latency: from the edge sampling the completing trig_i flag, trig_o is high in the cycle after the 2nd following edge (fixed 2-edge latency).
- Counters saturate at all-ones; they never wrap.
- count_clear_i:
  - Zeroes raw_count, acc_count and ph.
  - If it coincides with a fire, the clear wins: counts are 0 after the edge. trig_o is still emitted per the pre-clear phase.
  - Does not affect FSM, stretch or pattern.
- en_i[t] low: that trigger's stretch counters and cnt are cleared, FSM is forced to IDLE, trig_o[t]=0. Counters and pattern are held.
- Triggers are fully independent; simultaneous fires on several t in one cycle are all reported.
- Config changes take effect at the next edge; no shadowing.

Decomposition:
- Package radiant_trig_pkg holds:
  - the FSM state encoding (IDLE, HOLDOFF, REARM);
  - default width localparams;
  - the popcount width function clog2(NUM_CH+1).
- Sub-module radiant_coinc_unit covers one trigger: stretch, popcount, FSM, prescale and counters. The top generates NUM_TRIG instances and slices the config buses.

Test Plan:
- 2-of-3, window=4, thresh=2, prescale=0, holdoff=0:
  - ch0 at edge 10, ch5 at edge 13 → trig_o high after edge 15; pattern bits 0,5 set; raw=acc=1.
  - Repeat with ch5 at edge 15 → no trigger (window expired).
- Holdoff=20, thresh=1, pulses on ch0 every 5 cycles (windows overlap, so coinc stays high) → single fire; none until coinc drops after holdoff, then one fire on next ch0 pulse.
- prescale=2, thresh=1, holdoff=0: 9 separated fires → trig_o exactly 3 times (fires 3, 6, 9); raw=9, acc=3.
- COUNT_WIDTH=4, 20 fires → raw_count holds at 15.
- count_clear_i asserted on a fire edge → counts 0 afterwards.
- Veto and enable:
  - veto_i high across a coincidence → no trig_o, raw unchanged.
  - en_i[1] low during HOLDOFF → FSM IDLE next edge; trigger 0 unaffected.
- rst_ni low mid-HOLDOFF, asynchronous, between edges → all outputs 0 immediately.
- After release, thresh=1 with a ch flag → trig_o 2 edges later.
